// File: rtl/spline_cp_seq.sv
// Spline control-point sequencer: fetches Q_ORD points of a span and applies deltas.
// Define CP_SAT_ADD_EN to saturate the update sum instead of wrapping.
module spline_cp_seq #(
   parameter int WIDTH      = 16,
   parameter int Q_ORD      = 4,
   parameter int Q          = 13,
   parameter int SPAN_WIDTH = 5,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [SPAN_WIDTH-1:0]  span_ind,
   output logic [Q_ORD*WIDTH-1:0] q_vec_packed,
   output logic                   q_vec_valid,
   input  logic                   upd_valid,
   output logic                   upd_ready,
   input  logic [Q_ORD*WIDTH-1:0] delta_packed,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic                   mem_we,
   output logic [WIDTH-1:0]       mem_wdata,
   input  logic [WIDTH-1:0]       mem_rdata,
   output logic                   busy,
   output logic                   done,
   output logic                   span_clip
);

   localparam int KW   = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;
   localparam int SMAX = Q - Q_ORD;
   localparam logic [KW-1:0] KLAST = KW'(Q_ORD - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, DRAIN, WAIT_UPD, UPD_RD, UPD_WR
   } state_t;

   state_t                state_q;
   logic [KW-1:0]         k_q;
   logic [ADDR_WIDTH-1:0] span_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic                  qv_valid_q;
   logic                  done_q;
   logic                  clip_q;
   logic [WIDTH-1:0]      qv_q  [Q_ORD];
   logic [WIDTH-1:0]      dlt_q [Q_ORD];

   logic                  clip_d;
   logic [ADDR_WIDTH-1:0] span_d;
   logic [WIDTH-1:0]      dk;
   logic [WIDTH-1:0]      sum_w;

   assign clip_d = 32'(span_ind) > 32'(SMAX);
   assign span_d = clip_d ? ADDR_WIDTH'(SMAX) : ADDR_WIDTH'(span_ind);
   assign dk     = dlt_q[k_q];

`ifdef CP_SAT_ADD_EN
   logic [WIDTH:0] sum_x;
   assign sum_x = {mem_rdata[WIDTH-1], mem_rdata} + {dk[WIDTH-1], dk};
   // Sign bits disagree only on overflow; clamp toward the overflow direction.
   assign sum_w = (sum_x[WIDTH] != sum_x[WIDTH-1]) ?
                  (sum_x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}}) :
                  sum_x[WIDTH-1:0];
`else
   assign sum_w = mem_rdata + dk;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         k_q        <= '0;
         span_q     <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         qv_valid_q <= 1'b0;
         done_q     <= 1'b0;
         clip_q     <= 1'b0;
         for (int i = 0; i < Q_ORD; i++) begin
            qv_q[i]  <= '0;
            dlt_q[i] <= '0;
         end
      end else begin
         qv_valid_q <= 1'b0;
         done_q     <= 1'b0;
         clip_q     <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  span_q  <= span_d;
                  clip_q  <= clip_d;
                  k_q     <= '0;
                  addr_q  <= span_d;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               // Read data lags the address by one cycle.
               if (k_q != '0) qv_q[k_q - 1'b1] <= mem_rdata;
               if (k_q == KLAST) begin
                  addr_q  <= '0;
                  state_q <= DRAIN;
               end else begin
                  k_q    <= k_q + 1'b1;
                  addr_q <= span_q + ADDR_WIDTH'(k_q) + 1'b1;
               end
            end
            DRAIN: begin
               qv_q[KLAST] <= mem_rdata;
               qv_valid_q  <= 1'b1;
               state_q     <= WAIT_UPD;
            end
            WAIT_UPD: begin
               if (upd_valid) begin
                  for (int i = 0; i < Q_ORD; i++)
                     dlt_q[i] <= delta_packed[WIDTH*i +: WIDTH];
                  k_q     <= '0;
                  addr_q  <= span_q;
                  state_q <= UPD_RD;
               end
            end
            UPD_RD: begin
               we_q    <= 1'b1;
               state_q <= UPD_WR;
            end
            UPD_WR: begin
               we_q <= 1'b0;
               if (k_q == KLAST) begin
                  addr_q  <= '0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  k_q     <= k_q + 1'b1;
                  addr_q  <= span_q + ADDR_WIDTH'(k_q) + 1'b1;
                  state_q <= UPD_RD;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < Q_ORD; g++) begin : g_pack
      assign q_vec_packed[WIDTH*g +: WIDTH] = qv_q[g];
   end

   always_comb begin
      mem_wdata = '0;
      if (state_q == UPD_WR) mem_wdata = sum_w;
   end

   assign mem_addr    = addr_q;
   assign mem_we      = we_q;
   assign q_vec_valid = qv_valid_q;
   assign upd_ready   = (state_q == WAIT_UPD);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign span_clip   = clip_q;

endmodule

// File: tb/tb_spline_cp_seq.sv
// Scoreboard bench for spline_cp_seq with a behavioural 1-cycle-latency RAM.
module tb_spline_cp_seq;

   localparam int QO = 4;

`ifdef CP_SAT_ADD_EN
   localparam logic [15:0] E3A = 16'h7FFF;
   localparam logic [15:0] E3B = 16'h7FFF;
`else
   localparam logic [15:0] E3A = 16'h8009;
   localparam logic [15:0] E3B = 16'h800E;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  span_ind = '0;
   logic [63:0] q_vec_packed;
   logic        q_vec_valid;
   logic        upd_valid = 1'b0;
   logic        upd_ready;
   logic [63:0] delta_packed = '0;
   logic [3:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy, done, span_clip;

   logic [15:0] mem [16];
   logic        tb_we = 1'b0;
   logic [3:0]  tb_wa = '0;
   logic [15:0] tb_wd = '0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int we_cnt  = 0;
   logic [3:0] max_addr = '0;

   typedef struct {
      logic [63:0] v;
      int          c;
   } exp_t;
   exp_t qexp[$];
   int   dexp[$];
   exp_t e;
   int   dc;

   spline_cp_seq dut (
      .clk(clk), .reset(reset), .start(start), .span_ind(span_ind),
      .q_vec_packed(q_vec_packed), .q_vec_valid(q_vec_valid),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .delta_packed(delta_packed), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
      .done(done), .span_clip(span_clip)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else if (tb_we) mem[tb_wa] <= tb_wd;
      mem_rdata <= mem[mem_addr];
      cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exv);
      n_tests++;
      if (act !== exv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exv);
      end
   endtask

   always @(negedge clk) begin
      if (q_vec_valid === 1'b1) begin
         if (qexp.size() == 0) chk("qvec_unexpected", 1, 0);
         else begin
            e = qexp.pop_front();
            chk("qvec_data", q_vec_packed, e.v);
            chk("qvec_cycle", 64'(cyc), 64'(e.c));
         end
      end
      if (done === 1'b1) begin
         if (dexp.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            dc = dexp.pop_front();
            chk("done_cycle", 64'(cyc), 64'(dc));
         end
      end
      if (mem_addr > max_addr) max_addr = mem_addr;
      if (mem_we === 1'b1) we_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [3:0] a, input logic [15:0] d);
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      tick();
      tb_we = 1'b0;
   endtask

   task automatic fetch(input logic [4:0] s, input logic [3:0] base,
                        input logic clp, input logic [63:0] v);
      int t0;
      start = 1'b1; span_ind = s; t0 = cyc;
      qexp.push_back('{v, t0 + QO + 2});
      tick();
      start = 1'b0;
      chk("span_clip", span_clip, clp);
      for (int k = 0; k < QO; k++) begin
         chk("fetch_addr", {mem_we, mem_addr}, {1'b0, base + 4'(k)});
         tick();
      end
      chk("drain_not_ready", upd_ready, 0);
      tick();
      chk("wait_ready", upd_ready, 1);
   endtask

   task automatic update(input logic [63:0] d);
      int h, n;
      logic rdy;
      upd_valid = 1'b1; delta_packed = d; h = cyc;
      dexp.push_back(h + 2*QO + 1);
      tick();
      upd_valid = 1'b0;
      n = 0; rdy = 1'b0;
      while (busy && n < 40) begin
         if (upd_ready) rdy = 1'b1;
         tick();
         n++;
      end
      chk("upd_timeout", busy, 0);
      chk("ready_in_upd", rdy, 0);
      chk("upd_len", 64'(cyc - h), 64'(2*QO + 1));
   endtask

   initial begin
      int h, w;
      for (int i = 0; i < 16; i++) poke(4'(i), 16'(i*256));
      chk("rst_busy", busy, 0);
      chk("rst_ready", upd_ready, 0);
      chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
      chk("rst_qvec", q_vec_packed, 0);
      chk("rst_pulses", {q_vec_valid, done, span_clip}, 0);
      reset = 1'b0;
      tick();

      fetch(5'd3, 4'd3, 1'b0, {16'd1536, 16'd1280, 16'd1024, 16'd768});
      update({16'hFFFE, 16'h0002, 16'hFFFF, 16'h0001});
      chk("mem_3_6", {mem[6], mem[5], mem[4], mem[3]},
          {16'd1534, 16'd1282, 16'd1023, 16'd769});
      chk("done_now", done, 1);

      fetch(5'd20, 4'd9, 1'b1, {16'd3072, 16'd2816, 16'd2560, 16'd2304});
      start = 1'b1; span_ind = 5'd0;
      tick();
      start = 1'b0;
      chk("start_in_wait", {busy, upd_ready, mem_addr}, {1'b1, 1'b1, 4'd0});
      update(64'd0);
      chk("mem_9_12", {mem[12], mem[11], mem[10], mem[9]},
          {16'd3072, 16'd2816, 16'd2560, 16'd2304});
      upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      chk("upd_in_idle", {busy, upd_ready, mem_we}, 0);

      poke(4'd3, 16'h7FFF);
      fetch(5'd3, 4'd3, 1'b0, {16'd1534, 16'd1282, 16'd1023, 16'h7FFF});
      update({16'd0, 16'd0, 16'd0, 16'd10});
      chk("add_q3", mem[3], E3A);
      chk("add_rest", {mem[6], mem[5], mem[4]},
          {16'd1534, 16'd1282, 16'd1023});

      fetch(5'd3, 4'd3, 1'b0, {16'd1534, 16'd1282, 16'd1023, E3A});
      upd_valid = 1'b1;
      delta_packed = {16'd5, 16'd5, 16'd5, 16'd5};
      h = cyc;
      tick();
      upd_valid = 1'b0;
      while (cyc < h + 4) tick();
      chk("second_wr", {mem_we, mem_addr}, {1'b1, 4'd4});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", {busy, mem_we}, 0);
      w = we_cnt;
      repeat (6) tick();
      chk("no_more_we", 64'(we_cnt), 64'(w));
      chk("addr5_kept", {mem[6], mem[5]}, {16'd1534, 16'd1282});
      chk("partial", {mem[4], mem[3]}, {16'd1028, E3B});

      chk("qexp_empty", 64'(qexp.size()), 0);
      chk("dexp_empty", 64'(dexp.size()), 0);
      chk("max_addr_over", max_addr > 4'd12, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
